mem_stage: RTL

//   Memory (M) stage of the 5-stage MIPS pipeline, directly downstream of the execute stage.

---
 rtl/mips_defs_pkg.sv | 25 ++
 rtl/mem_stage_dm_ram.sv | 30 +++
 rtl/mem_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mips_defs_pkg.sv
// Shared MIPS definitions: memory-op opcodes, Tnew encodings and opcode classification helpers.
package mips_defs;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    localparam logic [1:0] TNEW_ZERO = 2'd0;
    localparam logic [1:0] TNEW_ONE  = 2'd1;

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

endpackage

// File: rtl/mem_stage_dm_ram.sv
// Word-organised data memory: byte-enabled synchronous write, asynchronous read, async clear.
module dm_ram #(
    parameter int WORDS = 1024,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    be,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    // NOTE: every word sits on the async reset because the pipeline relies on reads of
    // never-written locations returning 0; a RAM macro without clear would break that.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS M stage: E/M pipeline register, data memory access with byte/half merging,
// load extraction, sticky access-error flag and hazard-unit outputs.
module mem_stage
    import mips_defs::*;
#(
    parameter int          DM_WORDS = 1024,
    parameter logic [31:0] DM_BASE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_M,
    input  logic [31:0] Instr_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] ALUoutE,
    input  logic [31:0] RD2E,
    input  logic [4:0]  A3E,
    output logic [31:0] Instr_M,
    output logic [31:0] PC_M,
    output logic [31:0] ALUoutM,
    output logic [31:0] DMoutM,
    output logic [4:0]  A3M,
    output logic [4:0]  M_RFDst,
    output logic [1:0]  Tnew_M,
    output logic        dm_err
);

    localparam int          AW       = $clog2(DM_WORDS);
    localparam logic [31:0] DM_BYTES = 32'(4 * DM_WORDS);

    logic [31:0] instr_q, pc_q, alu_q, rd2_q;
    logic [4:0]  a3_q;

    // NOTE: state is written with <= so every register samples pre-edge values, no matter
    // how the statements are ordered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            rd2_q   <= '0;
            a3_q    <= '0;
        end else if (flush_M) begin
            instr_q <= '0;
            pc_q    <= '0;
            alu_q   <= '0;
            rd2_q   <= '0;
            a3_q    <= '0;
        end else begin
            instr_q <= Instr_E;
            pc_q    <= PC_E;
            alu_q   <= ALUoutE;
            rd2_q   <= RD2E;
            a3_q    <= A3E;
        end
    end

    logic [5:0]  op;
    logic        ld, st, misaligned, in_range, fault;
    logic [31:0] offset;

    assign op     = instr_q[31:26];
    assign ld     = is_load(op);
    assign st     = is_store(op);
    // Subtracting the base first makes addresses below DM_BASE wrap high and fail the range test.
    assign offset = alu_q - DM_BASE;
    assign in_range = offset < DM_BYTES;

    always_comb begin
        misaligned = 1'b0;
        unique case (op)
            OP_LW, OP_SW:         misaligned = alu_q[1:0] != 2'b00;
            OP_LH, OP_LHU, OP_SH: misaligned = alu_q[0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign fault = (ld || st) && (misaligned || !in_range);

    logic [3:0]  be;
    logic [31:0] wdata, rdata;

    // NOTE: be and wdata get defaults before the case so no path leaves them unassigned
    // (which would infer latches).
    always_comb begin
        be    = 4'b0000;
        wdata = rd2_q;
        unique case (op)
            OP_SW: be = 4'b1111;
            OP_SH: begin
                be    = alu_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rd2_q[15:0]}};
            end
            OP_SB: begin
                be    = 4'b0001 << alu_q[1:0];
                wdata = {4{rd2_q[7:0]}};
            end
            default: be = 4'b0000;
        endcase
        if (fault) be = 4'b0000;
    end

    dm_ram #(.WORDS(DM_WORDS), .AW(AW)) u_dm (
        .clk   (clk),
        .reset (reset),
        .addr  (offset[AW+1:2]),
        .be    (be),
        .wdata (wdata),
        .rdata (rdata)
    );

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;

    assign half_sel = alu_q[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        unique case (alu_q[1:0])
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
    end

    always_comb begin
        DMoutM = '0;
        unique case (op)
            OP_LW:   DMoutM = rdata;
            OP_LH:   DMoutM = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  DMoutM = {16'h0000, half_sel};
            OP_LB:   DMoutM = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  DMoutM = {24'h000000, byte_sel};
            default: DMoutM = '0;
        endcase
        if (fault) DMoutM = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     dm_err <= 1'b0;
        else if (fault) dm_err <= 1'b1;
    end

    assign Instr_M = instr_q;
    assign PC_M    = pc_q;
    assign ALUoutM = alu_q;
    assign A3M     = a3_q;
    assign M_RFDst = a3_q;
    assign Tnew_M  = ld ? TNEW_ONE : TNEW_ZERO;

endmodule
